// File: rtl/drain_deser.sv
// Drain-end deserializer: samples the inverter-chain bit, undoes the chain inversion,
// packs LSB-first WIDTH-bit words and queues them in a 2-entry valid/ready buffer.
module drain_deser #(
   parameter int   WIDTH  = 8,
   parameter logic INVERT = 1'b1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             drain,
   input  logic             drain_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] word_data,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overflow,
   input  logic             overflow_clr,
   output logic [3:0]       bit_count
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [3:0] LAST = 4'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_d;
   logic [3:0]       wr_pos;
   logic             b;
   logic             push;
   logic             pop;
   logic             ovf_evt;
   logic             full;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] new_word;
   logic [WIDTH-1:0] tail;

   assign b        = drain ^ INVERT;
   assign wr_pos   = sof ? 4'd0 : bit_count;
   assign new_word = {b, shreg[WIDTH-2:0]};
   assign pop      = word_valid & word_ready;
   assign ovf_evt  = push & full & ~pop;

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_count;
      push    = 1'b0;
      if (sof) begin
         // A frame start drops the partial word; a coincident strobe becomes bit 0.
         if (drain_valid) begin
            state_d = SHIFT;
            cnt_d   = 4'd1;
         end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      end else if (drain_valid) begin
         case (state_q)
            IDLE: begin
               state_d = SHIFT;
               cnt_d   = 4'd1;
            end
            SHIFT: begin
               if (bit_count == LAST) begin
                  push    = 1'b1;
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = bit_count + 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         bit_count <= 4'd0;
      end else begin
         state_q   <= state_d;
         bit_count <= cnt_d;
      end
   end

   // Partial-word bits are meaningless while bit_count is 0, so no reset is needed.
   always_ff @(posedge clock) begin
      if (drain_valid) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (wr_pos == 4'(i)) shreg[i] <= b;
         end
      end
   end

   // word_data is the head register; tail holds the second entry when full.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         word_data  <= '0;
         tail       <= '0;
         word_valid <= 1'b0;
         full       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (!word_valid) begin
                  word_data  <= new_word;
                  word_valid <= 1'b1;
               end else if (!full) begin
                  tail <= new_word;
                  full <= 1'b1;
               end
            end
            2'b01: begin
               if (full) begin
                  word_data <= tail;
                  full      <= 1'b0;
               end else begin
                  word_valid <= 1'b0;
               end
            end
            2'b11: begin
               if (full) begin
                  word_data <= tail;
                  tail      <= new_word;
               end else begin
                  word_data <= new_word;
               end
            end
            default: ;
         endcase
         overflow <= ovf_evt | (overflow & ~overflow_clr);
      end
   end

endmodule

// File: tb/tb_drain_deser.sv
// Directed bench for drain_deser (WIDTH=8, INVERT=1): per-cycle vector table plus
// hand-written sequences for frame restart, back-pressure, overflow and reset.
module tb_drain_deser;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       drain;
   logic       drain_valid;
   logic       sof;
   logic [7:0] word_data;
   logic       word_valid;
   logic       word_ready;
   logic       overflow;
   logic       overflow_clr;
   logic [3:0] bit_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       sof;
      logic       dv;
      logic       drn;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [7:0] ed;
      logic [3:0] ec;
      logic       eo;
   } vec_t;

   vec_t vt[$];

   drain_deser #(.WIDTH(8), .INVERT(1'b1)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .drain        (drain),
      .drain_valid  (drain_valid),
      .sof          (sof),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .bit_count    (bit_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic d, input logic dr, input logic r, input logic c);
      @(negedge clock);
      sof          = s;
      drain_valid  = d;
      drain        = dr;
      word_ready   = r;
      overflow_clr = c;
      @(posedge clock);
      #1;
   endtask

   // Drives drain as the inverse of each word bit, LSB first.
   task automatic send_word(input logic [7:0] w, input logic rdy_body, input logic rdy_last,
                            input logic clr);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, ~w[i], (i == 7) ? rdy_last : rdy_body, clr);
   endtask

   task automatic add(input logic s, input logic d, input logic dr, input logic r, input logic c,
                      input logic ev, input logic [7:0] ed, input logic [3:0] ec, input logic eo);
      vec_t v;
      v.sof = s; v.dv = d; v.drn = dr; v.rdy = r; v.clr = c;
      v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
      vt.push_back(v);
   endtask

   initial begin
      logic [7:0] w;
      reset_n      = 1'b0;
      drain        = 1'b0;
      drain_valid  = 1'b0;
      sof          = 1'b0;
      word_ready   = 1'b0;
      overflow_clr = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_valid", word_valid, 0);
      chk("rst_data", word_data, 0);
      chk("rst_count", bit_count, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clock);
      reset_n = 1'b1;

      // Basic word 8'hA5 back-to-back, then the same word with a gap after every strobe.
      w = 8'hA5;
      for (int i = 0; i < 8; i++)
         add(1'b0, 1'b1, ~w[i], 1'b1, 1'b0, (i == 7), w, (i == 7) ? 4'd0 : 4'(i + 1), 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         add(1'b0, 1'b1, ~w[i], 1'b1, 1'b0, (i == 7), w, (i == 7) ? 4'd0 : 4'(i + 1), 1'b0);
         add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, (i == 7) ? 4'd0 : 4'(i + 1), 1'b0);
      end

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].sof, vt[i].dv, vt[i].drn, vt[i].rdy, vt[i].clr);
         chk($sformatf("vec%0d_valid", i), word_valid, vt[i].ev);
         chk($sformatf("vec%0d_count", i), bit_count, vt[i].ec);
         chk($sformatf("vec%0d_ovf", i), overflow, vt[i].eo);
         if (vt[i].ev) chk($sformatf("vec%0d_data", i), word_data, vt[i].ed);
      end

      // sof restart: 5 bits, then sof with a strobe, then 7 more zero bits -> one 8'h00.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("sof_pre_count", bit_count, 5);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("sof_count", bit_count, 1);
      chk("sof_no_word", word_valid, 0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
         chk($sformatf("sof_mid%0d_valid", i), word_valid, 0);
      end
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("sof_word_valid", word_valid, 1);
      chk("sof_word_data", word_data, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("sof_popped", word_valid, 0);

      // sof without a strobe drops the partial word.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("sof_idle_count", bit_count, 0);

      // Push and pop with one entry held: head replaced, count stays at one.
      send_word(8'h11, 1'b0, 1'b0, 1'b0);
      send_word(8'h55, 1'b0, 1'b1, 1'b0);
      chk("pp1_valid", word_valid, 1);
      chk("pp1_data", word_data, 8'h55);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("pp1_empty", word_valid, 0);

      // Back-pressure: third word dropped; clear held high on that edge still loses to set.
      send_word(8'h11, 1'b0, 1'b0, 1'b0);
      chk("bp_w1_data", word_data, 8'h11);
      chk("bp_w1_valid", word_valid, 1);
      send_word(8'h22, 1'b0, 1'b0, 1'b0);
      chk("bp_w2_data", word_data, 8'h11);
      chk("bp_w2_ovf", overflow, 0);
      send_word(8'h33, 1'b0, 1'b0, 1'b1);
      chk("bp_w3_ovf", overflow, 1);
      chk("bp_w3_data", word_data, 8'h11);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("bp_pop1_data", word_data, 8'h22);
      chk("bp_pop1_valid", word_valid, 1);
      chk("bp_sticky", overflow, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("bp_pop2_valid", word_valid, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("bp_clr", overflow, 0);

      // Full buffer with push and pop on the same edge.
      send_word(8'h11, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 1'b0);
      send_word(8'h44, 1'b0, 1'b1, 1'b0);
      chk("fpp_ovf", overflow, 0);
      chk("fpp_head", word_data, 8'h22);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fpp_next", word_data, 8'h44);
      chk("fpp_next_valid", word_valid, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fpp_empty", word_valid, 0);

      // Asynchronous reset mid-word with a full, overflowed buffer.
      send_word(8'h11, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 1'b0);
      send_word(8'h33, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_ovf", overflow, 1);
      chk("pre_rst_count", bit_count, 3);
      @(negedge clock);
      drain_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", word_valid, 0);
      chk("arst_count", bit_count, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_data", word_data, 0);
      @(negedge clock);
      reset_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_valid", word_valid, 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_word_valid", word_valid, 1);
      chk("post_rst_word_data", word_data, 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
